// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP              = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: synchronous FIFO with flush,
// registered count/full/empty, and pc+4 derived at the head.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(QUEUE_DEPTH):0] count,
  output logic [INSTR_W-1:0]           head_data,
  output logic [ADDR_W-1:0]            head_pc,
  output logic [ADDR_W-1:0]            head_pc_plus4
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  fetch_entry_t       mem_q [QUEUE_DEPTH];
  fetch_entry_t       mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               push_en, pop_en;
  fetch_entry_t       head;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_en   = pop & ~empty_q;
    // A push into a full queue is only legal when the head leaves the same cycle.
    push_en  = push & (~full_q | pop_en);

    if (push_en) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    head_data     = '0;
    head_pc       = '0;
    head_pc_plus4 = '0;
    if (!empty_q) begin
      head_data     = head.data;
      head_pc       = head.pc;
      head_pc_plus4 = head.pc + PC_STEP;
    end
  end

  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: drives the PC register, fetches over req/ack,
// buffers instructions and hands {instr, pc, pc+4} to decode.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                QUEUE_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc_in,
  output logic [ADDR_W-1:0]   pc_next,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr_data,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [ADDR_W-1:0]   instr_pc_plus4
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(QUEUE_DEPTH - 1);

  // Memory handshake: a request is outstanding while imem_req is high; the
  // address is held until imem_ack. Decode handshake: the head transfers on
  // instr_valid & instr_ready and is held stable otherwise.
  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
  logic [ADDR_W-1:0]  fetch_pc, target;
  logic               q_push, q_pop, q_empty, q_full, fetch_stays;
  logic [CNT_W-1:0]   q_count;
  fetch_entry_t       q_entry;
  logic [INSTR_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_pc, head_pc_plus4;

  assign fetch_pc = align_word(pc_in);
  assign target   = align_word(redirect_target);

  assign instr_valid    = ~reset & ~q_empty;
  assign instr_data     = reset ? '0 : head_data;
  assign instr_pc       = reset ? '0 : head_pc;
  assign instr_pc_plus4 = reset ? '0 : head_pc_plus4;
  assign q_pop          = instr_valid & instr_ready;

  assign imem_req  = ~reset & (state_q != IDLE);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc;

  // Keep fetching only if this cycle's push leaves room for the next one.
  assign fetch_stays = q_pop | (q_count < DEPTH_M1);

  always_comb begin
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    pc_next      = pc_in;
    q_push       = 1'b0;
    q_entry.data = imem_rdata;
    q_entry.pc   = fetch_pc;

    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_next = target;
          state_d = FETCH;
        end else if (!q_full) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack && !redirect_valid) begin
          q_push  = 1'b1;
          pc_next = fetch_pc + PC_STEP;
          state_d = fetch_stays ? FETCH : IDLE;
        end else if (!imem_ack && redirect_valid) begin
          drain_addr_d = fetch_pc;
          pc_next      = target;
          state_d      = DRAIN;
        end else if (imem_ack && redirect_valid) begin
          pc_next = target;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_next = target;
        end else if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      pc_next = RESET_VECTOR;
      q_push  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .flush        (redirect_valid),
    .push         (q_push),
    .push_entry   (q_entry),
    .pop          (q_pop),
    .empty        (q_empty),
    .full         (q_full),
    .count        (q_count),
    .head_data    (head_data),
    .head_pc      (head_pc),
    .head_pc_plus4(head_pc_plus4)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register and latency-programmable instruction
// memory around the DUT, reference instruction stream kept as a PC sequence.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset, imem_req, imem_ack, redirect_valid, instr_valid, instr_ready;
  logic [31:0] pc_in, pc_next, imem_addr, imem_rdata, redirect_target;
  logic [31:0] instr_data, instr_pc, instr_pc_plus4;
  logic [31:0] pc_reg = 32'h0;

  always #5 clock = ~clock;

  assign pc_in = pc_reg;
  always @(posedge clock) pc_reg <= pc_next;

  fetch_unit #(.QUEUE_DEPTH(2), .RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [31:0] exp_q[$];
  logic [31:0] stream_pc = RV;
  logic [31:0] pcn_log[$], addr_log[$], hpc_log[$];
  logic        req_log[$], valid_log[$];
  int          out_cnt = 0, ack_cnt = 0, total_out = 0, gap = 0, max_gap = 0;
  bit          pend_prev = 0;
  logic [31:0] pend_addr = '0;

  always @(negedge clock) begin
    logic [31:0] e;
    if (reset) begin
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr_data", instr_data, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_instr_pc_plus4", instr_pc_plus4, 32'd0);
      chk("rst_pc_next", pc_next, RV);
      exp_q.delete();
      stream_pc = RV;
      pcn_log.delete(); addr_log.delete(); hpc_log.delete();
      req_log.delete(); valid_log.delete();
      out_cnt = 0; ack_cnt = 0; gap = 0; pend_prev = 0;
    end else begin
      pcn_log.push_back(pc_next);
      addr_log.push_back(imem_addr);
      hpc_log.push_back(instr_pc);
      req_log.push_back(imem_req);
      valid_log.push_back(instr_valid);
      if (pend_prev) begin
        chk("mem_req_held", {31'b0, imem_req}, 32'd1);
        chk("mem_addr_stable", imem_addr, pend_addr);
      end
      if (imem_req) chk("mem_addr_aligned", imem_addr & 32'h3, 32'd0);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(stream_pc);
          stream_pc = stream_pc + 32'd4;
        end
        e = exp_q.pop_front();
        chk("out_pc", instr_pc, e);
        chk("out_data", instr_data, mem_word(e));
        chk("out_pc_plus4", instr_pc_plus4, e + 32'd4);
        out_cnt++; total_out++; gap = 0;
      end else begin
        gap++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        stream_pc = redirect_target & ~32'h3;
        gap = 0;
      end
      if (gap > max_gap) max_gap = gap;
      pend_prev = imem_req && !imem_ack;
      pend_addr = imem_addr;
      if (imem_req && imem_ack) ack_cnt++;
    end
  end

  // ---------------- driver / memory model ----------------
  int lat_min = 0, lat_max = 0, lat = 0, wait_cnt = 0;
  bit busy = 0, late_ack = 0;

  task automatic drive_cycle(input bit rst, input bit redir, input logic [31:0] tgt, input bit rdy);
    @(posedge clock);
    #1;
    reset = rst; redirect_valid = redir; redirect_target = tgt; instr_ready = rdy;
    #1;
    if (late_ack) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; busy = 0;
    end else if (imem_req) begin
      if (!busy) begin
        busy = 1; wait_cnt = 0; lat = $urandom_range(lat_max, lat_min);
      end
      if (wait_cnt >= lat) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); busy = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom; wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom; busy = 0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    int ones, base_out;
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; instr_ready = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // Zero-latency memory, decode always ready: one instruction per cycle.
    lat_min = 0; lat_max = 0;
    do_reset(3);
    repeat (20) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    chk("tp_log_len", pcn_log.size(), 32'd20);
    chk("tp_outputs", out_cnt, 32'd18);
    ones = 0;
    for (int k = 1; k < 20; k++) ones += req_log[k];
    chk("tp_req_never_drops", ones, 32'd19);
    for (int k = 0; k < 20; k++) chk("tp_pc_next_seq", pcn_log[k], 32'(4 * k));
    for (int k = 2; k < 5; k++) chk("tp_instr_pc_seq", hpc_log[k], 32'(4 * (k - 2)));

    // Three-cycle memory latency: address held, one instruction per 4 cycles.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    repeat (42) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    chk("slow_outputs", out_cnt, 32'd10);
    for (int k = 1; k < 5; k++) begin
      chk("slow_req", {31'b0, req_log[k]}, 32'd1);
      chk("slow_addr_held", addr_log[k], 32'h0);
    end
    for (int k = 1; k < 4; k++) chk("slow_pc_hold", pcn_log[k], 32'h0);
    chk("slow_pc_advance", pcn_log[4], 32'h4);

    // Decode stalled: two entries fetched, then IDLE with head held.
    lat_min = 0; lat_max = 0;
    do_reset(2);
    repeat (8) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("stall_acks", ack_cnt, 32'd2);
    for (int k = 3; k < 8; k++) chk("stall_req_low", {31'b0, req_log[k]}, 32'd0);
    for (int k = 2; k < 8; k++) begin
      chk("stall_valid", {31'b0, valid_log[k]}, 32'd1);
      chk("stall_head_pc", hpc_log[k], 32'h0);
    end
    repeat (6) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    chk("stall_release_outputs", out_cnt, 32'd5);

    // Redirect while waiting for the ack of 0x8: DRAIN then refetch at 0x100.
    lat_min = 3; lat_max = 3;
    do_reset(2);
    for (int k = 0; k < 18; k++) drive_cycle(1'b0, k == 10, 32'h100, 1'b1);
    settle();
    for (int k = 9; k < 13; k++) begin
      chk("drain_req", {31'b0, req_log[k]}, 32'd1);
      chk("drain_addr", addr_log[k], 32'h8);
    end
    chk("drain_pc_next", pcn_log[10], 32'h100);
    chk("drain_refetch_addr", addr_log[13], 32'h100);
    chk("drain_discarded", {31'b0, valid_log[13]}, 32'd0);
    chk("drain_first_pc", hpc_log[17], 32'h100);
    chk("drain_first_valid", {31'b0, valid_log[17]}, 32'd1);
    chk("drain_outputs", out_cnt, 32'd3);

    // Redirect to an unaligned target coinciding with an ack.
    lat_min = 0; lat_max = 0;
    do_reset(2);
    for (int k = 0; k < 10; k++) drive_cycle(1'b0, k == 4, 32'h203, 1'b1);
    settle();
    chk("redir_ack_pc_next", pcn_log[4], 32'h200);
    chk("redir_ack_flushed", {31'b0, valid_log[5]}, 32'd0);
    chk("redir_ack_refetch", addr_log[5], 32'h200);
    chk("redir_ack_first_pc", hpc_log[6], 32'h200);

    // Reset while a fetch is outstanding, with a late ack across the reset.
    lat_min = 0; lat_max = 0;
    do_reset(2);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    lat_min = 8; lat_max = 8;
    repeat (3) drive_cycle(1'b0, 1'b0, 32'h0, 1'b0);
    late_ack = 1;
    do_reset(2);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    late_ack = 0;
    lat_min = 0; lat_max = 0;
    repeat (9) drive_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    settle();
    chk("late_ack_pc_next", pcn_log[0], RV);
    chk("late_ack_ignored_c0", {31'b0, valid_log[0]}, 32'd0);
    chk("late_ack_ignored_c1", {31'b0, valid_log[1]}, 32'd0);
    chk("late_ack_restart_pc", hpc_log[2], 32'h0);
    chk("late_ack_restart_valid", {31'b0, valid_log[2]}, 32'd1);

    // Randomised traffic: latency, back-pressure, redirects (incl. wrap), resets.
    lat_min = 0; lat_max = 3;
    do_reset(1);
    max_gap = 0;
    base_out = total_out;
    for (int k = 0; k < 3000; k++) begin
      bit          r, rd;
      logic [31:0] t;
      r  = ($urandom_range(999) < 3);
      rd = !r && ($urandom_range(99) < 5);
      t  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
      drive_cycle(r, rd, t, $urandom_range(99) < 70);
    end
    settle();
    chk("rand_progress", {31'b0, (total_out - base_out) > 300}, 32'd1);
    chk("rand_no_stall", {31'b0, max_gap < 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
